hssim_ratio_pipe: RTL



---
 rtl/hssim_ratio_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hssim_ratio_pipe.sv
// Per-lane SSIM numerator/denominator stage: three stall-able pipeline stages
// with frame-beat counting and a per-frame full / structure-only mode tag.
module hssim_ratio_pipe #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int MU_WIDTH        = 8,
  parameter int SIG_WIDTH       = 18,
  parameter int NUMR_BIT_WIDTH  = 36,
  parameter int DENR_BIT_WIDTH  = 36,
  parameter int C1              = 7,
  parameter int C2              = 59
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  stall,
  input  logic                                  mode,
  input  logic                                  in_valid,
  input  logic [MU_WIDTH*PIXELS_PER_BEAT-1:0]   mu_x,
  input  logic [MU_WIDTH*PIXELS_PER_BEAT-1:0]   mu_y,
  input  logic [SIG_WIDTH*PIXELS_PER_BEAT-1:0]  sig_sq_x,
  input  logic [SIG_WIDTH*PIXELS_PER_BEAT-1:0]  sig_sq_y,
  input  logic [SIG_WIDTH*PIXELS_PER_BEAT-1:0]  sig_xy,
  output logic [NUMR_BIT_WIDTH*PIXELS_PER_BEAT-1:0] numr_out,
  output logic [DENR_BIT_WIDTH*PIXELS_PER_BEAT-1:0] denr_out,
  output logic                                  out_valid,
  output logic                                  out_last
);

  localparam int BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = 2 * MU_WIDTH + 4;
  localparam int SW    = SIG_WIDTH + 4;
  localparam int PW    = AW + SW;
  localparam int OW    = (NUMR_BIT_WIDTH > DENR_BIT_WIDTH) ? NUMR_BIT_WIDTH : DENR_BIT_WIDTH;
  localparam int RW    = ((PW > OW) ? PW : OW) + 1;

  localparam logic signed [RW-1:0] NUMR_MAX =
    $signed({{(RW-NUMR_BIT_WIDTH+1){1'b0}}, {(NUMR_BIT_WIDTH-1){1'b1}}});
  localparam logic signed [RW-1:0] NUMR_MIN = ~NUMR_MAX;
  localparam logic signed [RW-1:0] DENR_MAX =
    $signed({{(RW-DENR_BIT_WIDTH+1){1'b0}}, {(DENR_BIT_WIDTH-1){1'b1}}});
  localparam logic signed [RW-1:0] DENR_MIN = ~DENR_MAX;

  function automatic logic signed [NUMR_BIT_WIDTH-1:0] sat_numr(input logic signed [RW-1:0] v);
    if (v > NUMR_MAX)      return NUMR_MAX[NUMR_BIT_WIDTH-1:0];
    else if (v < NUMR_MIN) return NUMR_MIN[NUMR_BIT_WIDTH-1:0];
    else                   return v[NUMR_BIT_WIDTH-1:0];
  endfunction

  function automatic logic signed [DENR_BIT_WIDTH-1:0] sat_denr(input logic signed [RW-1:0] v);
    if (v > DENR_MAX)      return DENR_MAX[DENR_BIT_WIDTH-1:0];
    else if (v < DENR_MIN) return DENR_MIN[DENR_BIT_WIDTH-1:0];
    else                   return v[DENR_BIT_WIDTH-1:0];
  endfunction

  logic [CW-1:0] in_cnt_reg;
  logic          mode_f_reg;
  logic          v1_reg, v2_reg, l1_reg, l2_reg, m1_reg, m2_reg;

  logic cnt_first, cnt_last, mode_cur;
  assign cnt_first = (in_cnt_reg == '0);
  assign cnt_last  = (in_cnt_reg == CW'(BEATS - 1));
  // Beat 0 of a frame uses the live mode pin; later beats use the latched copy.
  assign mode_cur  = cnt_first ? mode : mode_f_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_reg <= '0;
      mode_f_reg <= 1'b0;
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      l1_reg     <= 1'b0;
      l2_reg     <= 1'b0;
      m1_reg     <= 1'b0;
      m2_reg     <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (!stall) begin
      v1_reg    <= in_valid;
      l1_reg    <= in_valid & cnt_last;
      m1_reg    <= mode_cur;
      v2_reg    <= v1_reg;
      l2_reg    <= l1_reg;
      m2_reg    <= m1_reg;
      out_valid <= v2_reg;
      out_last  <= l2_reg;
      if (in_valid) begin
        in_cnt_reg <= cnt_last ? '0 : in_cnt_reg + 1'b1;
        if (cnt_first) mode_f_reg <= mode;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PIXELS_PER_BEAT; gi++) begin : g_lane
      logic [MU_WIDTH-1:0]         mx, my;
      logic signed [SIG_WIDTH-1:0] sxx, syy, sxy;
      logic [2*MU_WIDTH-1:0]       p_mm_reg;
      logic [2*MU_WIDTH:0]         p_sq_reg;
      logic signed [SIG_WIDTH:0]   s_sum_reg, s_xy2_reg;
      logic signed [AW-1:0]        a_reg, b_reg;
      logic signed [SW-1:0]        c_reg, d_reg;
      logic signed [NUMR_BIT_WIDTH-1:0] numr_reg;
      logic signed [DENR_BIT_WIDTH-1:0] denr_reg;
      logic signed [RW-1:0]        numr_full, denr_full;

      assign mx  = mu_x[gi*MU_WIDTH +: MU_WIDTH];
      assign my  = mu_y[gi*MU_WIDTH +: MU_WIDTH];
      assign sxx = sig_sq_x[gi*SIG_WIDTH +: SIG_WIDTH];
      assign syy = sig_sq_y[gi*SIG_WIDTH +: SIG_WIDTH];
      assign sxy = sig_xy[gi*SIG_WIDTH +: SIG_WIDTH];

      // RW is wider than any product, so only the final narrowing can saturate.
      always_comb begin
        numr_full = '0;
        denr_full = '0;
        if (m2_reg) begin
          numr_full = RW'(c_reg);
          denr_full = RW'(d_reg);
        end else begin
          numr_full = RW'(a_reg) * RW'(c_reg);
          denr_full = RW'(b_reg) * RW'(d_reg);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          p_mm_reg  <= '0;
          p_sq_reg  <= '0;
          s_sum_reg <= '0;
          s_xy2_reg <= '0;
          a_reg     <= '0;
          b_reg     <= '0;
          c_reg     <= '0;
          d_reg     <= '0;
          numr_reg  <= '0;
          denr_reg  <= '0;
        end else if (!stall) begin
          p_mm_reg  <= (2*MU_WIDTH)'(mx) * (2*MU_WIDTH)'(my);
          p_sq_reg  <= (2*MU_WIDTH+1)'(mx) * (2*MU_WIDTH+1)'(mx)
                     + (2*MU_WIDTH+1)'(my) * (2*MU_WIDTH+1)'(my);
          s_sum_reg <= (SIG_WIDTH+1)'(sxx) + (SIG_WIDTH+1)'(syy);
          s_xy2_reg <= {sxy, 1'b0};
          a_reg     <= $signed({{(AW-2*MU_WIDTH-1){1'b0}}, p_mm_reg, 1'b0}) + AW'(C1);
          b_reg     <= $signed({{(AW-2*MU_WIDTH-1){1'b0}}, p_sq_reg}) + AW'(C1);
          c_reg     <= SW'(s_xy2_reg) + SW'(C2);
          d_reg     <= SW'(s_sum_reg) + SW'(C2);
          numr_reg  <= sat_numr(numr_full);
          denr_reg  <= sat_denr(denr_full);
        end
      end

      assign numr_out[gi*NUMR_BIT_WIDTH +: NUMR_BIT_WIDTH] = numr_reg;
      assign denr_out[gi*DENR_BIT_WIDTH +: DENR_BIT_WIDTH] = denr_reg;
    end
  endgenerate

endmodule
